// File: rtl/bitlogic_pkg.sv
// Shared op encodings and helpers for the bitwise logic unit.
package bitlogic_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'b000;
  localparam logic [OP_W-1:0] OP_OR   = 3'b001;
  localparam logic [OP_W-1:0] OP_NAND = 3'b010;
  localparam logic [OP_W-1:0] OP_NOR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
  localparam logic [OP_W-1:0] OP_XNOR = 3'b101;

  // Codes 110 and 111 carry no operation.
  function automatic logic is_reserved(input logic [OP_W-1:0] op);
    return (op[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/bitlogic_core.sv
// Combinational bitwise op on two WIDTH-bit operands; reserved codes yield zero.
module bitlogic_core
  import bitlogic_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/bitlogic_unit.sv
// Registered bitwise logic unit with valid/ready handshake, sticky error and beat counter.
// Optional accumulator operand enabled by defining BITLOGIC_ACC_EN.
module bitlogic_unit
  import bitlogic_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             err_sticky,
  input  logic             err_clr,
  output logic [CNT_W-1:0] beat_cnt
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_result;
  logic             r_out_zero;
  logic             r_err_sticky;
  logic [CNT_W-1:0] r_beat_cnt;

  logic             w_accept;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_result;

  // Skid-free single-entry slot: accept whenever the slot is empty or draining.
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

`ifdef BITLOGIC_ACC_EN
  logic [WIDTH-1:0] r_acc;

  assign w_op_a = in_acc ? r_acc : in_a;

  // Clear takes priority over an accumulating write in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
    end else if (acc_clr) begin
      r_acc <= '0;
    end else if (w_accept && in_acc) begin
      r_acc <= w_result;
    end
  end
`else
  logic w_unused_acc;

  assign w_op_a       = in_a;
  assign w_unused_acc = in_acc ^ acc_clr;
`endif

  bitlogic_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a      (w_op_a),
    .b      (in_b),
    .op     (in_op),
    .result (w_result)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_zero   <= 1'b0;
    end else begin
      r_out_valid <= w_accept || (r_out_valid && !out_ready);
      if (w_accept) begin
        r_out_result <= w_result;
        r_out_zero   <= (w_result == '0);
      end
    end
  end

  // Error set beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_sticky <= 1'b0;
    end else if (w_accept && is_reserved(in_op)) begin
      r_err_sticky <= 1'b1;
    end else if (err_clr) begin
      r_err_sticky <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      r_beat_cnt <= r_beat_cnt + CNT_W'(1);
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_zero   = r_out_zero;
  assign err_sticky = r_err_sticky;
  assign beat_cnt   = r_beat_cnt;

endmodule

// File: tb/tb_bitlogic_unit.sv
// Self-checking bench for bitlogic_unit: directed scenarios plus randomized traffic vs a truth-table model.
module tb_bitlogic_unit;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [2:0]       in_op = '0;
  logic             in_acc = 1'b0;
  logic             acc_clr = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             err_sticky;
  logic             err_clr = 1'b0;
  logic [CNT_W-1:0] beat_cnt;

  int n_total = 0;
  int n_pass  = 0;

  bitlogic_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .in_acc     (in_acc),
    .acc_clr    (acc_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .err_sticky (err_sticky),
    .err_clr    (err_clr),
    .beat_cnt   (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Per-op truth table indexed by {a_bit, b_bit}.
  function automatic logic [WIDTH-1:0] ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [2:0] op);
    logic [3:0] tt [0:7];
    logic [WIDTH-1:0] r;
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0111; tt[3] = 4'b0001;
    tt[4] = 4'b0110; tt[5] = 4'b1001; tt[6] = 4'b0000; tt[7] = 4'b0000;
    for (int i = 0; i < int'(WIDTH); i++) r[i] = tt[op][{a[i], b[i]}];
    return r;
  endfunction

  // Behavioural model state
  logic             m_valid  = 1'b0;
  logic [WIDTH-1:0] m_result = '0;
  logic             m_zero   = 1'b0;
  logic             m_err    = 1'b0;
  int               m_beats  = 0;
  logic [WIDTH-1:0] m_acc    = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid  <= 1'b0;
      m_result <= '0;
      m_zero   <= 1'b0;
      m_err    <= 1'b0;
      m_beats  <= 0;
      m_acc    <= '0;
    end else begin
      automatic logic acc_mode = 1'b0;
      automatic logic take = in_valid && (!m_valid || out_ready);
      automatic logic [WIDTH-1:0] opa;
      automatic logic [WIDTH-1:0] res;
`ifdef BITLOGIC_ACC_EN
      acc_mode = in_acc;
`endif
      opa = acc_mode ? m_acc : in_a;
      res = ref_op(opa, in_b, in_op);
      if (take) begin
        m_valid  <= 1'b1;
        m_result <= res;
        m_zero   <= (res == 0);
        m_beats  <= m_beats + 1;
        if (in_op >= 3'd6) m_err <= 1'b1;
        else if (err_clr) m_err <= 1'b0;
      end else begin
        if (out_ready) m_valid <= 1'b0;
        if (err_clr) m_err <= 1'b0;
      end
`ifdef BITLOGIC_ACC_EN
      if (acc_clr) m_acc <= '0;
      else if (take && in_acc) m_acc <= res;
`endif
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("in_ready",   32'(in_ready),   32'(!m_valid || out_ready));
      chk("out_valid",  32'(out_valid),  32'(m_valid));
      chk("out_result", 32'(out_result), 32'(m_result));
      chk("out_zero",   32'(out_zero),   32'(m_zero));
      chk("err_sticky", 32'(err_sticky), 32'(m_err));
      chk("beat_cnt",   32'(beat_cnt),   32'(m_beats % (1 << CNT_W)));
    end
  end

  initial begin
    logic [WIDTH-1:0] exp_b2b [0:5];
    logic [CNT_W-1:0] saved_cnt;
    exp_b2b[0] = 8'h30; exp_b2b[1] = 8'hFC; exp_b2b[2] = 8'hCF;
    exp_b2b[3] = 8'h03; exp_b2b[4] = 8'hCC; exp_b2b[5] = 8'h33;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid",  32'(out_valid),  32'h0);
    chk("rst_result", 32'(out_result), 32'h0);
    chk("rst_zero",   32'(out_zero),   32'h0);
    chk("rst_err",    32'(err_sticky), 32'h0);
    chk("rst_cnt",    32'(beat_cnt),   32'h0);
    chk("rst_ready",  32'(in_ready),   32'h1);
    @(posedge clk); #1 reset_n = 1'b1;

    // Back-to-back ops on F0/3C
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 8'hF0; in_b = 8'h3C; in_op = 3'd0; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (k < 5) in_op = 3'(k + 1);
      else in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_result", 32'(out_result), 32'(exp_b2b[k]));
      chk("b2b_valid",  32'(out_valid),  32'h1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain_valid", 32'(out_valid), 32'h0);

    // Stall for several cycles with a beat waiting
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = 3'd0; in_a = 8'hFF; in_b = 8'h0F;
    @(posedge clk); #1;
    out_ready = 1'b0; in_op = 3'd1; in_a = 8'h12; in_b = 8'h40;
    saved_cnt = beat_cnt;
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready",  32'(in_ready),   32'h0);
      chk("stall_result", 32'(out_result), 32'h0F);
      chk("stall_cnt",    32'(beat_cnt),   32'(saved_cnt));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("release_result", 32'(out_result), 32'h52);
    chk("release_cnt",    32'(beat_cnt),   32'(saved_cnt + 4'd1));

    // Reserved ops and sticky error priority
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = 3'd6; in_a = 8'hA5; in_b = 8'h5A;
    @(posedge clk); #1;
    in_op = 3'd7; err_clr = 1'b1;
    @(negedge clk);
    chk("rsv_result", 32'(out_result), 32'h00);
    chk("rsv_zero",   32'(out_zero),   32'h1);
    chk("rsv_err",    32'(err_sticky), 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    chk("err_set_wins", 32'(err_sticky), 32'h1);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("err_cleared", 32'(err_sticky), 32'h0);

    // Async reset while a result is pending
    @(posedge clk); #1;
    in_valid = 1'b1; out_ready = 1'b0; in_op = 3'd1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 32'h1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'h0);
    chk("async_rst_cnt",   32'(beat_cnt),  32'h0);
    @(posedge clk); #1 reset_n = 1'b1;

    // 17 accepts wrap a 4-bit counter to 1
    out_ready = 1'b1; in_valid = 1'b1;
    repeat (17) begin
      in_op = 3'($urandom_range(0, 5)); in_a = 8'($urandom); in_b = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("cnt_wrap", 32'(beat_cnt), 32'h1);

`ifdef BITLOGIC_ACC_EN
    // Accumulator chain and clear-vs-accumulate priority
    @(posedge clk); #1 acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0; in_valid = 1'b1; in_acc = 1'b1; in_a = 8'hAA; in_op = 3'd1; in_b = 8'h0F;
    @(posedge clk); #1;
    in_op = 3'd4; in_b = 8'hFF;
    @(negedge clk);
    chk("acc_or", 32'(out_result), 32'h0F);
    @(posedge clk); #1;
    acc_clr = 1'b1; in_op = 3'd0; in_b = 8'hFF;
    @(negedge clk);
    chk("acc_xor", 32'(out_result), 32'hF0);
    @(posedge clk); #1;
    acc_clr = 1'b0; in_op = 3'd1; in_b = 8'h00;
    @(negedge clk);
    chk("acc_clr_beat", 32'(out_result), 32'hF0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_acc = 1'b0;
    @(negedge clk);
    chk("acc_after_clr", 32'(out_result), 32'h00);
`endif

    // Randomized traffic; the negedge compare process checks every cycle
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 3) != 0);
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      in_op     = 3'($urandom);
      err_clr   = 1'($urandom_range(0, 7) == 0);
      in_acc    = 1'($urandom_range(0, 1));
      acc_clr   = 1'($urandom_range(0, 9) == 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; err_clr = 1'b0; acc_clr = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
